// File: rtl/fa_pipe_n.sv
// Pipelined W-bit adder/subtractor: each of STAGES stages adds one W/STAGES-bit
// slice, with a valid/ready handshake and per-stage valid bits so bubbles collapse.
module fa_pipe_n #(
  parameter int W      = 16,
  parameter int STAGES = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         c_in,
  input  logic         sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] s,
  output logic         c_out,
  output logic         ovf
);

  localparam int SW = W / STAGES;

  // One in-flight beat: operands (effective B already folded in), the sum
  // slices completed so far and the carry into the next slice.
  typedef struct packed {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] s;
    logic         cy;
  } beat_t;

  logic [STAGES-1:0] vld_q, vld_d;
  logic [STAGES-1:0] adv;
  logic [STAGES-1:0] load;
  logic              in_rdy;
  beat_t             stg_q [STAGES];
  beat_t             stg_d [STAGES];
  beat_t             src   [STAGES];

  // Handshake: walk from the output back to the input; a stage advances when
  // it holds a beat and the stage after it can take one this cycle.
  always_comb begin
    logic dn_rdy;
    // NOTE: combinational logic uses blocking '=' so each iteration sees the
    // value just computed; state registers below use non-blocking '<='.
    dn_rdy = out_ready;
    adv    = '0;
    for (int k = STAGES - 1; k >= 0; k--) begin
      adv[k] = vld_q[k] && dn_rdy;
      dn_rdy = !vld_q[k] || adv[k];
    end
    in_rdy = dn_rdy;

    load    = '0;
    load[0] = in_valid && in_rdy;
    for (int k = 1; k < STAGES; k++) begin
      load[k] = adv[k-1];
    end

    for (int k = 0; k < STAGES; k++) begin
      vld_d[k] = load[k] || (vld_q[k] && !adv[k]);
    end
  end

  // Datapath: stage k adds slice k of its source beat and records the carry.
  always_comb begin
    logic [SW:0] sl;
    sl     = '0;
    src[0] = '{a: a, b: (sub ? ~b : b), s: '0, cy: (sub | c_in)};
    for (int k = 1; k < STAGES; k++) begin
      src[k] = stg_q[k-1];
    end
    for (int k = 0; k < STAGES; k++) begin
      sl = {1'b0, src[k].a[k*SW +: SW]} + {1'b0, src[k].b[k*SW +: SW]}
         + {{SW{1'b0}}, src[k].cy};
      stg_d[k]                = src[k];
      stg_d[k].s[k*SW +: SW]  = sl[SW-1:0];
      stg_d[k].cy             = sl[SW];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      // NOTE: the datapath registers are reset too, because the result
      // outputs read straight from the last stage and must be zero in reset.
      for (int k = 0; k < STAGES; k++) begin
        stg_q[k] <= '0;
      end
    end else begin
      vld_q <= vld_d;
      for (int k = 0; k < STAGES; k++) begin
        if (load[k]) begin
          stg_q[k] <= stg_d[k];
        end
      end
    end
  end

  assign in_ready  = in_rdy;
  assign out_valid = vld_q[STAGES-1];
  assign s         = stg_q[STAGES-1].s;
  assign c_out     = stg_q[STAGES-1].cy;
  // Signed overflow: operands agree in sign but the sum does not.
  assign ovf       = (stg_q[STAGES-1].a[W-1] == stg_q[STAGES-1].b[W-1]) &&
                     (stg_q[STAGES-1].s[W-1] != stg_q[STAGES-1].a[W-1]);

endmodule

// File: tb/tb_fa_pipe_n.sv
// Directed bench for fa_pipe_n (W=16, STAGES=4) plus a randomised sweep over
// four W=8 instances (STAGES 1, 2, 4, 8) scored against a whole-width model.
module tb_fa_pipe_n;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic        c_in, sub, c_out, ovf;
  logic [15:0] a, b, s;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  fa_pipe_n #(.W(16), .STAGES(4)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .c_in      (c_in),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .s         (s),
    .c_out     (c_out),
    .ovf       (ovf)
  );

  // Random-sweep instances share stimulus; each keeps its own handshake.
  logic [7:0] ra, rb;
  logic       rcin, rsub, rin_valid, rout_ready;
  logic [3:0] rrdy, rvld, rco, rov;
  logic [7:0] rs [4];

  for (genvar g = 0; g < 4; g++) begin : g_rnd
    fa_pipe_n #(.W(8), .STAGES(1 << g)) u_rdut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (rin_valid),
      .in_ready  (rrdy[g]),
      .a         (ra),
      .b         (rb),
      .c_in      (rcin),
      .sub       (rsub),
      .out_valid (rvld[g]),
      .out_ready (rout_ready),
      .s         (rs[g]),
      .c_out     (rco[g]),
      .ovf       (rov[g])
    );
  end

  logic [9:0] exp_q [4][$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [15:0] aa, input logic [15:0] bb, input logic ci, input logic su);
    a        = aa;
    b        = bb;
    c_in     = ci;
    sub      = su;
    in_valid = 1'b1;
  endtask

  // Reference: whole-width add of a, effective B and effective carry-in.
  function automatic logic [17:0] model(input int w, input logic [15:0] aa, input logic [15:0] bb,
                                        input logic ci, input logic su);
    logic [16:0] mask, eb, r;
    logic [15:0] sv;
    logic        co, ov;
    mask = (17'd1 << w) - 17'd1;
    eb   = su ? (~{1'b0, bb}) & mask : {1'b0, bb};
    r    = {1'b0, aa} + eb + (su ? 17'd1 : {16'd0, ci});
    co   = r[w];
    sv   = r[15:0] & mask[15:0];
    ov   = (aa[w-1] == eb[w-1]) && (sv[w-1] != aa[w-1]);
    return {ov, co, sv};
  endfunction

  task automatic single(input string tag, input logic [15:0] aa, input logic [15:0] bb,
                        input logic ci, input logic su,
                        input logic [15:0] es, input logic ec, input logic eo);
    bit seen;
    seen = 1'b0;
    drive(aa, bb, ci, su);
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      if (out_valid) begin
        seen = 1'b1;
        check({tag, "_s"}, 32'(s), 32'(es));
        check({tag, "_c_out"}, 32'(c_out), 32'(ec));
        check({tag, "_ovf"}, 32'(ovf), 32'(eo));
      end
      tick();
    end
    check({tag, "_arrived"}, 32'(seen), 32'd1);
  endtask

  initial begin
    int         idx, got, stale;
    bit         acc, first;
    logic [17:0] m;
    logic [9:0]  e;

    in_valid   = 1'b0;
    out_ready  = 1'b1;
    a          = '0;
    b          = '0;
    c_in       = 1'b0;
    sub        = 1'b0;
    ra         = '0;
    rb         = '0;
    rcin       = 1'b0;
    rsub       = 1'b0;
    rin_valid  = 1'b0;
    rout_ready = 1'b1;

    // Reset state, before any clock edge.
    #2;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_s", 32'(s), 32'd0);
    check("rst_c_out", 32'(c_out), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    tick();
    tick();
    rst_n = 1'b1;

    // Max add; accepted on the first edge after reset, valid 3 edges later.
    drive(16'hFFFF, 16'hFFFF, 1'b0, 1'b0);
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    check("lat_not_early", 32'(out_valid), 32'd0);
    tick();
    check("lat_valid", 32'(out_valid), 32'd1);
    check("max_s", 32'(s), 32'h0000_FFFE);
    check("max_c_out", 32'(c_out), 32'd1);
    check("max_ovf", 32'(ovf), 32'd0);
    tick();
    check("max_consumed", 32'(out_valid), 32'd0);

    // Back-to-back beats, one result per cycle.
    drive(16'd10, 16'd23, 1'b0, 1'b0);
    tick();
    drive(16'd42, 16'd5, 1'b1, 1'b0);
    tick();
    drive(16'd90, 16'd170, 1'b1, 1'b0);
    tick();
    in_valid = 1'b0;
    tick();
    check("b2b0_valid", 32'(out_valid), 32'd1);
    check("b2b0_s", 32'(s), 32'd33);
    tick();
    check("b2b1_valid", 32'(out_valid), 32'd1);
    check("b2b1_s", 32'(s), 32'd48);
    tick();
    check("b2b2_valid", 32'(out_valid), 32'd1);
    check("b2b2_s", 32'(s), 32'd261);
    check("b2b2_c_out", 32'(c_out), 32'd0);
    tick();

    // Subtract and signed-overflow corners.
    single("sub_5_10", 16'd5, 16'd10, 1'b0, 1'b1, 16'hFFFB, 1'b0, 1'b0);
    single("sub_min_1", 16'h8000, 16'd1, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
    single("add_max_1", 16'h7FFF, 16'd1, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);

    // Backpressure: six beats offered, four absorbed, held result stable.
    out_ready = 1'b0;
    idx       = 0;
    for (int cyc = 0; cyc < 6; cyc++) begin
      drive(16'(idx * 32'h1111), 16'h0101, 1'b0, 1'b0);
      #1;
      acc = in_ready;
      tick();
      if (acc) idx++;
    end
    check("bp_absorbed", 32'(idx), 32'd4);
    check("bp_in_ready_low", 32'(in_ready), 32'd0);
    check("bp_out_valid", 32'(out_valid), 32'd1);
    check("bp_hold_s", 32'(s), 32'h0000_0101);
    tick();
    check("bp_hold_s_stable", 32'(s), 32'h0000_0101);
    check("bp_hold_valid_stable", 32'(out_valid), 32'd1);

    out_ready = 1'b1;
    got       = 0;
    first     = 1'b1;
    for (int cyc = 0; cyc < 40 && got < 6; cyc++) begin
      if (idx < 6) drive(16'(idx * 32'h1111), 16'h0101, 1'b0, 1'b0);
      else         in_valid = 1'b0;
      #1;
      if (first) begin
        check("full_accept_and_consume", 32'(in_ready), 32'd1);
        first = 1'b0;
      end
      acc = in_valid && in_ready;
      if (out_valid) begin
        check($sformatf("drain_s[%0d]", got), 32'(s), 32'(16'(got * 32'h1111 + 32'h0101)));
        got++;
      end
      tick();
      if (acc) idx++;
    end
    in_valid = 1'b0;
    check("drain_count", 32'(got), 32'd6);
    check("drain_accepted", 32'(idx), 32'd6);

    // Mid-flight reset with three beats in the pipe.
    out_ready = 1'b0;
    drive(16'h8001, 16'h8001, 1'b0, 1'b0);
    tick();
    drive(16'd1, 16'd1, 1'b0, 1'b0);
    tick();
    drive(16'd2, 16'd2, 1'b0, 1'b0);
    tick();
    in_valid = 1'b0;
    tick();
    check("pre_rst_valid", 32'(out_valid), 32'd1);
    check("pre_rst_s", 32'(s), 32'h0000_0002);
    check("pre_rst_c_out", 32'(c_out), 32'd1);
    check("pre_rst_ovf", 32'(ovf), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", 32'(out_valid), 32'd0);
    check("async_rst_s", 32'(s), 32'd0);
    check("async_rst_c_out", 32'(c_out), 32'd0);
    check("async_rst_ovf", 32'(ovf), 32'd0);
    check("async_rst_in_ready", 32'(in_ready), 32'd1);
    tick();
    tick();
    rst_n     = 1'b1;
    out_ready = 1'b1;
    drive(16'd1, 16'd2, 1'b0, 1'b0);
    tick();
    in_valid = 1'b0;
    tick();
    check("post_rst_no_stale1", 32'(out_valid), 32'd0);
    tick();
    check("post_rst_no_stale2", 32'(out_valid), 32'd0);
    tick();
    check("post_rst_first_valid", 32'(out_valid), 32'd1);
    check("post_rst_first_s", 32'(s), 32'd3);
    tick();
    stale = 0;
    for (int i = 0; i < 6; i++) begin
      if (out_valid) stale++;
      tick();
    end
    check("post_rst_quiet", 32'(stale), 32'd0);

    // Random sweep on the W=8 instances; last cycles drain with no new input.
    for (int cyc = 0; cyc < 700; cyc++) begin
      ra   = 8'($urandom);
      rb   = 8'($urandom);
      rcin = 1'($urandom);
      rsub = 1'($urandom);
      if (cyc < 640) begin
        rin_valid  = ($urandom_range(0, 3) != 0);
        rout_ready = ($urandom_range(0, 2) != 0);
      end else begin
        rin_valid  = 1'b0;
        rout_ready = 1'b1;
      end
      #1;
      for (int k = 0; k < 4; k++) begin
        if (rin_valid && rrdy[k]) begin
          m = model(8, {8'd0, ra}, {8'd0, rb}, rcin, rsub);
          exp_q[k].push_back({m[17], m[16], m[7:0]});
        end
        if (rvld[k] && rout_ready) begin
          check($sformatf("rnd_expected_pending[%0d]", k), 32'(exp_q[k].size() != 0), 32'd1);
          if (exp_q[k].size() != 0) begin
            e = exp_q[k].pop_front();
            check($sformatf("rnd_result[%0d]", k), 32'({rov[k], rco[k], rs[k]}), 32'(e));
          end
        end
      end
      tick();
    end
    for (int k = 0; k < 4; k++) begin
      check($sformatf("rnd_leftover[%0d]", k), 32'(exp_q[k].size()), 32'd0);
    end
    check("rnd_idle", 32'(rvld), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fa_pipe_n.md
FA_PIPE_N -- requirements
Module: fa_pipe_n

Interface
REQ-001 Parameter W, default 16: operand and sum width in bits, >= 2.
REQ-002 Parameter STAGES, default 4: pipeline depth; >= 1 and divides W; each stage adds one W/STAGES-bit slice.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 in_valid  input  1  operand beat presented.
REQ-006 in_ready  output  1  block accepts a beat this cycle.
REQ-007 a  input  W  operand A.
REQ-008 b  input  W  operand B.
REQ-009 c_in  input  1  carry-in; used in add mode only.
REQ-010 sub  input  1  0 = add, 1 = subtract; sampled with the beat.
REQ-011 out_valid  output  1  result beat presented.
REQ-012 out_ready  input  1  downstream accepts the result.
REQ-013 s  output  W  sum/difference.
REQ-014 c_out  output  1  carry out of bit W-1.
REQ-015 ovf  output  1  two's-complement signed overflow.

Function
REQ-016 A beat is accepted when in_valid and in_ready are both 1 at a rising edge; a result is consumed when out_valid and out_ready are both 1.
REQ-017 Effective B = sub ? ~b : b; effective carry-in = sub ? 1 : c_in; result = a + effective B + effective carry-in, computed modulo 2^(W+1).
REQ-018 s = result[W-1:0]; c_out = result[W]; in subtract mode c_out = 1 means no borrow.
REQ-019 ovf = 1 when a[W-1] equals effective-B[W-1] and s[W-1] differs from it; otherwise 0.
REQ-020 Stage k (0..STAGES-1) adds slice k using the carry registered from stage k-1; stage 0 uses the effective carry-in.
REQ-021 Operand slices not yet consumed and completed sum slices travel with their beat through pipeline registers; no combinational path spans more than one slice carry chain.
REQ-022 Each stage holds a valid bit; a stage loads when it is empty or its contents advance in the same cycle.
REQ-023 Latency with out_ready held 1: a beat accepted at edge N appears with out_valid = 1 after edge N+STAGES-1; throughput one beat per cycle.
REQ-024 in_ready = !stage0_valid || stage0_advances; no combinational path from in_valid to in_ready.
REQ-025 out_ready = 0 holds the final stage; s, c_out and ovf remain stable while out_valid = 1 and out_ready = 0.
REQ-026 Backpressure fills empty stages first; with out_ready low, the pipeline absorbs exactly STAGES beats before in_ready drops.
REQ-027 Beats leave in acceptance order; no beat is lost or duplicated under any in_valid/out_ready pattern.
REQ-028 Accept and consume in the same cycle with a full pipeline: both occur; occupancy is unchanged.
REQ-029 STAGES = 1 degenerates to a single registered W-bit adder with the same handshake.

Reset
REQ-030 While rst_n = 0: all stage valid bits are 0, out_valid = 0, s = 0, c_out = 0, ovf = 0, in_ready = 1; this takes effect immediately, without waiting for clk.
REQ-031 Reset asserted mid-operation discards all in-flight beats; no result from them appears after release.
REQ-032 First beat may be accepted on the first rising edge after rst_n rises.

Verification (W=16, STAGES=4 unless stated)
REQ-033 a=0xFFFF, b=0xFFFF, c_in=0, sub=0 -> s=0xFFFE, c_out=1, ovf=0, out_valid after 3 further edges.
REQ-034 Back-to-back beats with out_ready=1: (10,23,0) (42,5,1) (90,170,1), add mode -> s=33, 48, 261 on consecutive cycles, c_out=0.
REQ-035 Subtract: a=5, b=10 -> s=0xFFFB, c_out=0, ovf=0; a=0x8000, b=1 -> s=0x7FFF, c_out=1, ovf=1; add a=0x7FFF, b=1, c_in=0 -> s=0x8000, ovf=1.
REQ-036 out_ready=0 with 6 beats offered -> exactly 4 accepted, in_ready=0 afterwards; out_ready=1 then yields all 6 results in order.
REQ-037 rst_n pulsed low with 3 beats in flight -> outputs 0 and in_ready=1 immediately; no stale result after release.
REQ-038 Random sweep, W=8 with STAGES 1, 2, 4, 8 -> every result equals the REQ-017 reference model under random in_valid/out_ready.
